// File: rtl/axi_burst_addr_gen.sv
// axi_burst_addr_gen
//   Accepts one AXI AW/AR request and walks it out as one address beat per
//   transfer (FIXED / INCR / WRAP), with byte strobes, last and an error flag.
//   Optional build macro: AXI_4K_CHECK_EN. When defined, an INCR burst that
//   crosses a 4 KB boundary is flagged with beat_err for every beat.
module axi_burst_addr_gen #(
    parameter int DATA_BYTES = 4,
    parameter int ADDR_W     = 32
) (
    input  logic                  i_aclk,
    input  logic                  i_areset,
    input  logic                  i_req_valid,
    output logic                  o_req_ready,
    input  logic [8:0]            i_req_id,
    input  logic [ADDR_W-1:0]     i_req_addr,
    input  logic [7:0]            i_req_len,
    input  logic [2:0]            i_req_size,
    input  logic [1:0]            i_req_burst,
    output logic                  o_beat_valid,
    input  logic                  i_beat_ready,
    output logic [8:0]            o_beat_id,
    output logic [ADDR_W-1:0]     o_beat_addr,
    output logic [DATA_BYTES-1:0] o_beat_strb,
    output logic [7:0]            o_beat_idx,
    output logic                  o_beat_last,
    output logic                  o_beat_err,
    output logic [15:0]           o_total_bytes
);

    // Number of address bits that select a byte lane (DATA_BYTES >= 2 assumed).
    localparam int LSB = $clog2(DATA_BYTES);

    localparam logic [1:0] B_FIXED = 2'd0;
    localparam logic [1:0] B_INCR  = 2'd1;
    localparam logic [1:0] B_WRAP  = 2'd2;
    localparam logic [1:0] B_RSVD  = 2'd3;

    typedef enum logic {S_IDLE = 1'b0, S_BURST = 1'b1} state_t;

    state_t              r_state;
    state_t              w_state_next;

    logic [8:0]          r_id;
    logic [ADDR_W-1:0]   r_addr;
    logic [7:0]          r_len;
    logic [2:0]          r_size;
    logic [1:0]          r_mode;
    logic [7:0]          r_idx;
    logic                r_err;
    logic [15:0]         r_total;
    logic [ADDR_W-1:0]   r_wrap_bound;
    logic [ADDR_W-1:0]   r_wrap_high;

    // ---------------- request parsing ----------------
    logic                w_accept;
    logic [15:0]         w_req_bytes;
    logic [15:0]         w_req_total;
    logic [ADDR_W-1:0]   w_req_mask;
    logic [ADDR_W-1:0]   w_req_aligned;
    logic [ADDR_W-1:0]   w_req_wrap_bound;
    logic [ADDR_W-1:0]   w_req_wrap_high;
    logic                w_len_wrap_ok;
    logic                w_4k_err;
    logic                w_req_err;
    logic [1:0]          w_req_mode;

    assign w_accept         = (r_state == S_IDLE) && i_req_valid;
    assign w_req_bytes      = 16'd1 << i_req_size;
    assign w_req_total      = (16'(i_req_len) + 16'd1) << i_req_size;
    assign w_req_mask       = ADDR_W'(w_req_bytes) - ADDR_W'(1);
    assign w_req_aligned    = i_req_addr & ~w_req_mask;
    assign w_req_wrap_bound = i_req_addr & ~(ADDR_W'(w_req_total) - ADDR_W'(1));
    assign w_req_wrap_high  = w_req_wrap_bound + ADDR_W'(w_req_total);
    assign w_len_wrap_ok    = (i_req_len == 8'd1) || (i_req_len == 8'd3) ||
                              (i_req_len == 8'd7) || (i_req_len == 8'd15);

`ifdef AXI_4K_CHECK_EN
    logic [ADDR_W-1:0]   w_req_last_byte;
    assign w_req_last_byte = w_req_aligned + ADDR_W'(w_req_total) - ADDR_W'(1);
    assign w_4k_err = (i_req_burst == B_INCR) &&
                      (w_req_last_byte[ADDR_W-1:12] != i_req_addr[ADDR_W-1:12]);
`else
    assign w_4k_err = 1'b0;
`endif

    assign w_req_err = (i_req_burst == B_RSVD) ||
                       (i_req_size > 3'(LSB)) ||
                       ((i_req_burst == B_WRAP) &&
                        (!w_len_wrap_ok || ((i_req_addr & w_req_mask) != '0))) ||
                       w_4k_err;

    // Illegal requests are walked out as INCR so downstream still sees len+1 beats.
    assign w_req_mode = w_req_err ? B_INCR : i_req_burst;

    // ---------------- beat address stepping ----------------
    logic [ADDR_W-1:0]   w_cur_mask;
    logic [ADDR_W-1:0]   w_cur_aligned;
    logic [ADDR_W-1:0]   w_incr_addr;
    logic [ADDR_W-1:0]   w_next_addr;
    logic                w_last;
    logic [LSB-1:0]      w_lane_lo;
    logic [LSB-1:0]      w_lane_hi;
    logic [DATA_BYTES-1:0] w_strb;

    assign w_cur_mask    = ADDR_W'(16'd1 << r_size) - ADDR_W'(1);
    assign w_cur_aligned = r_addr & ~w_cur_mask;
    assign w_incr_addr   = w_cur_aligned + w_cur_mask + ADDR_W'(1);
    assign w_last        = (r_idx == r_len);

    // Pick the following beat's address for the latched burst mode.
    always_comb begin
        w_next_addr = w_incr_addr;
        case (r_mode)
            B_FIXED: w_next_addr = r_addr;
            B_WRAP:  w_next_addr = (w_incr_addr == r_wrap_high) ? r_wrap_bound : w_incr_addr;
            default: w_next_addr = w_incr_addr;
        endcase
    end

    // Lanes run from the (possibly unaligned) address up to the end of the
    // aligned transfer; oversize transfers saturate at the top lane.
    assign w_lane_lo = r_addr[LSB-1:0];
    assign w_lane_hi = r_addr[LSB-1:0] | w_cur_mask[LSB-1:0];

    for (genvar gi = 0; gi < DATA_BYTES; gi++) begin : g_strb
        assign w_strb[gi] = (LSB'(gi) >= w_lane_lo) && (LSB'(gi) <= w_lane_hi);
    end

    // ---------------- FSM ----------------
    // State register; reset aborts any burst immediately.
    always_ff @(posedge i_aclk or posedge i_areset) begin
        if (i_areset) r_state <= S_IDLE;
        else          r_state <= w_state_next;
    end

    // Next-state: IDLE waits for a request, BURST ends on the accepted last beat.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (i_req_valid) w_state_next = S_BURST;
            S_BURST: if (i_beat_ready && w_last) w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    // Outputs: handshakes from state, flags gated so nothing is asserted when idle.
    always_comb begin
        o_req_ready   = (r_state == S_IDLE);
        o_beat_valid  = (r_state == S_BURST);
        o_beat_last   = (r_state == S_BURST) && w_last;
        o_beat_err    = (r_state == S_BURST) && r_err;
        o_beat_strb   = (r_state == S_BURST) ? w_strb : '0;
        o_beat_id     = r_id;
        o_beat_addr   = r_addr;
        o_beat_idx    = r_idx;
        o_total_bytes = r_total;
    end

    // Datapath: latch the parsed request, then step index/address per accepted beat.
    always_ff @(posedge i_aclk or posedge i_areset) begin
        if (i_areset) begin
            r_id         <= '0;
            r_addr       <= '0;
            r_len        <= '0;
            r_size       <= '0;
            r_mode       <= '0;
            r_idx        <= '0;
            r_err        <= 1'b0;
            r_total      <= '0;
            r_wrap_bound <= '0;
            r_wrap_high  <= '0;
        end else if (w_accept) begin
            r_id         <= i_req_id;
            r_addr       <= i_req_addr;
            r_len        <= i_req_len;
            r_size       <= i_req_size;
            r_mode       <= w_req_mode;
            r_idx        <= '0;
            r_err        <= w_req_err;
            r_total      <= w_req_total;
            r_wrap_bound <= w_req_wrap_bound;
            r_wrap_high  <= w_req_wrap_high;
        end else if ((r_state == S_BURST) && i_beat_ready && !w_last) begin
            r_idx        <= r_idx + 8'd1;
            r_addr       <= w_next_addr;
        end
    end

endmodule

// File: tb/tb_axi_burst_addr_gen.sv
// Directed testbench for axi_burst_addr_gen (DATA_BYTES=4, ADDR_W=32).
// Honours AXI_4K_CHECK_EN for the 4 KB crossing expectation.
module tb_axi_burst_addr_gen;

    logic        i_aclk = 1'b0;
    logic        i_areset;
    logic        i_req_valid;
    logic        o_req_ready;
    logic [8:0]  i_req_id;
    logic [31:0] i_req_addr;
    logic [7:0]  i_req_len;
    logic [2:0]  i_req_size;
    logic [1:0]  i_req_burst;
    logic        o_beat_valid;
    logic        i_beat_ready;
    logic [8:0]  o_beat_id;
    logic [31:0] o_beat_addr;
    logic [3:0]  o_beat_strb;
    logic [7:0]  o_beat_idx;
    logic        o_beat_last;
    logic        o_beat_err;
    logic [15:0] o_total_bytes;

    int n_tests = 0;
    int n_fail  = 0;

`ifdef AXI_4K_CHECK_EN
    localparam logic EXP_4K_ERR = 1'b1;
`else
    localparam logic EXP_4K_ERR = 1'b0;
`endif

    axi_burst_addr_gen #(.DATA_BYTES(4), .ADDR_W(32)) dut (
        .i_aclk        (i_aclk),
        .i_areset      (i_areset),
        .i_req_valid   (i_req_valid),
        .o_req_ready   (o_req_ready),
        .i_req_id      (i_req_id),
        .i_req_addr    (i_req_addr),
        .i_req_len     (i_req_len),
        .i_req_size    (i_req_size),
        .i_req_burst   (i_req_burst),
        .o_beat_valid  (o_beat_valid),
        .i_beat_ready  (i_beat_ready),
        .o_beat_id     (o_beat_id),
        .o_beat_addr   (o_beat_addr),
        .o_beat_strb   (o_beat_strb),
        .o_beat_idx    (o_beat_idx),
        .o_beat_last   (o_beat_last),
        .o_beat_err    (o_beat_err),
        .o_total_bytes (o_total_bytes)
    );

    always #5 i_aclk = ~i_aclk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_val);
        n_tests++;
        if (obs !== exp_val) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp_val);
        end
    endtask

    // Present one request for a single cycle (we sit on negedges throughout).
    task automatic send_req(input logic [8:0] id, input logic [31:0] a, input logic [7:0] len,
                            input logic [2:0] size, input logic [1:0] burst);
        int k;
        k = 0;
        while (!o_req_ready && k < 20) begin
            @(negedge i_aclk);
            k++;
        end
        check("req_ready", 64'(o_req_ready), 64'd1);
        i_req_id    = id;
        i_req_addr  = a;
        i_req_len   = len;
        i_req_size  = size;
        i_req_burst = burst;
        i_req_valid = 1'b1;
        @(negedge i_aclk);
        i_req_valid = 1'b0;
        $display("[TB] req id=%03h addr=%08h len=%0d size=%0d burst=%0d", id, a, len, size, burst);
    endtask

    // Check the currently presented beat, then hand it downstream.
    task automatic beat(input string tag, input logic [31:0] a, input logic [3:0] s,
                        input logic [7:0] idx, input logic last, input logic err);
        check({tag, ".valid"}, 64'(o_beat_valid), 64'd1);
        check({tag, ".addr"},  64'(o_beat_addr),  64'(a));
        check({tag, ".strb"},  64'(o_beat_strb),  64'(s));
        check({tag, ".idx"},   64'(o_beat_idx),   64'(idx));
        check({tag, ".last"},  64'(o_beat_last),  64'(last));
        check({tag, ".err"},   64'(o_beat_err),   64'(err));
        $display("[TB] beat %s idx=%0d addr=%08h strb=%h last=%0b err=%0b",
                 tag, o_beat_idx, o_beat_addr, o_beat_strb, o_beat_last, o_beat_err);
        i_beat_ready = 1'b1;
        @(negedge i_aclk);
    endtask

    task automatic burst_done(input string tag);
        i_beat_ready = 1'b0;
        check({tag, ".end_valid"}, 64'(o_beat_valid), 64'd0);
        check({tag, ".end_ready"}, 64'(o_req_ready),  64'd1);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        i_areset     = 1'b1;
        i_req_valid  = 1'b0;
        i_req_id     = '0;
        i_req_addr   = '0;
        i_req_len    = '0;
        i_req_size   = '0;
        i_req_burst  = '0;
        i_beat_ready = 1'b0;
        repeat (2) @(negedge i_aclk);

        // Reset state
        check("rst.req_ready", 64'(o_req_ready),   64'd1);
        check("rst.valid",     64'(o_beat_valid),  64'd0);
        check("rst.last",      64'(o_beat_last),   64'd0);
        check("rst.err",       64'(o_beat_err),    64'd0);
        check("rst.addr",      64'(o_beat_addr),   64'd0);
        check("rst.strb",      64'(o_beat_strb),   64'd0);
        check("rst.total",     64'(o_total_bytes), 64'd0);
        i_areset = 1'b0;
        @(negedge i_aclk);

        // INCR aligned, back-to-back beats
        send_req(9'h1A5, 32'h100, 8'd3, 3'd2, 2'd1);
        check("incr.id",    64'(o_beat_id),     64'h1A5);
        check("incr.total", 64'(o_total_bytes), 64'd16);
        beat("incr0", 32'h100, 4'hF, 8'd0, 1'b0, 1'b0);
        beat("incr1", 32'h104, 4'hF, 8'd1, 1'b0, 1'b0);
        beat("incr2", 32'h108, 4'hF, 8'd2, 1'b0, 1'b0);
        beat("incr3", 32'h10C, 4'hF, 8'd3, 1'b1, 1'b0);
        burst_done("incr");

        // WRAP
        send_req(9'h012, 32'h38, 8'd3, 3'd2, 2'd2);
        check("wrap.total", 64'(o_total_bytes), 64'd16);
        beat("wrap0", 32'h38, 4'hF, 8'd0, 1'b0, 1'b0);
        beat("wrap1", 32'h3C, 4'hF, 8'd1, 1'b0, 1'b0);
        beat("wrap2", 32'h30, 4'hF, 8'd2, 1'b0, 1'b0);
        beat("wrap3", 32'h34, 4'hF, 8'd3, 1'b1, 1'b0);
        burst_done("wrap");

        // INCR unaligned start
        send_req(9'h003, 32'h101, 8'd1, 3'd2, 2'd1);
        beat("unal0", 32'h101, 4'hE, 8'd0, 1'b0, 1'b0);
        beat("unal1", 32'h104, 4'hF, 8'd1, 1'b1, 1'b0);
        burst_done("unal");

        // FIXED with stalls; a competing request during the burst is refused
        send_req(9'h104, 32'h20, 8'd2, 3'd1, 2'd0);
        check("fix.total", 64'(o_total_bytes), 64'd6);
        i_req_addr  = 32'h999;
        i_req_valid = 1'b1;
        @(negedge i_aclk);
        check("fix.busy_ready", 64'(o_req_ready), 64'd0);
        check("fix.hold0_addr", 64'(o_beat_addr), 64'h20);
        check("fix.hold0_idx",  64'(o_beat_idx),  64'd0);
        i_req_valid = 1'b0;
        beat("fix0", 32'h20, 4'h3, 8'd0, 1'b0, 1'b0);
        i_beat_ready = 1'b0;
        @(negedge i_aclk);
        check("fix.hold1_idx",   64'(o_beat_idx),   64'd1);
        check("fix.hold1_valid", 64'(o_beat_valid), 64'd1);
        beat("fix1", 32'h20, 4'h3, 8'd1, 1'b0, 1'b0);
        i_beat_ready = 1'b0;
        @(negedge i_aclk);
        beat("fix2", 32'h20, 4'h3, 8'd2, 1'b1, 1'b0);
        burst_done("fix");

        // Reserved burst type
        send_req(9'h005, 32'h40, 8'd1, 3'd2, 2'd3);
        beat("rsvd0", 32'h40, 4'hF, 8'd0, 1'b0, 1'b1);
        beat("rsvd1", 32'h44, 4'hF, 8'd1, 1'b1, 1'b1);
        burst_done("rsvd");

        // WRAP with illegal length, walked as INCR
        send_req(9'h006, 32'h10, 8'd2, 3'd2, 2'd2);
        beat("wlen0", 32'h10, 4'hF, 8'd0, 1'b0, 1'b1);
        beat("wlen1", 32'h14, 4'hF, 8'd1, 1'b0, 1'b1);
        beat("wlen2", 32'h18, 4'hF, 8'd2, 1'b1, 1'b1);
        burst_done("wlen");

        // Oversize transfer
        send_req(9'h007, 32'h0, 8'd0, 3'd3, 2'd1);
        beat("size0", 32'h0, 4'hF, 8'd0, 1'b1, 1'b1);
        burst_done("size");

        // 4 KB crossing
        send_req(9'h008, 32'hFF8, 8'd3, 3'd2, 2'd1);
        beat("x4k0", 32'hFF8,  4'hF, 8'd0, 1'b0, EXP_4K_ERR);
        beat("x4k1", 32'hFFC,  4'hF, 8'd1, 1'b0, EXP_4K_ERR);
        beat("x4k2", 32'h1000, 4'hF, 8'd2, 1'b0, EXP_4K_ERR);
        beat("x4k3", 32'h1004, 4'hF, 8'd3, 1'b1, EXP_4K_ERR);
        burst_done("x4k");

        // Asynchronous reset in the middle of a burst
        send_req(9'h009, 32'h0, 8'd7, 3'd2, 2'd1);
        beat("ar0", 32'h0, 4'hF, 8'd0, 1'b0, 1'b0);
        beat("ar1", 32'h4, 4'hF, 8'd1, 1'b0, 1'b0);
        i_beat_ready = 1'b0;
        check("ar.beat2_addr", 64'(o_beat_addr), 64'h8);
        #2 i_areset = 1'b1;
        #1;
        check("ar.async_valid", 64'(o_beat_valid), 64'd0);
        check("ar.async_ready", 64'(o_req_ready),  64'd1);
        @(negedge i_aclk);
        i_areset = 1'b0;
        @(negedge i_aclk);
        check("ar.post_valid", 64'(o_beat_valid), 64'd0);
        check("ar.post_ready", 64'(o_req_ready),  64'd1);
        check("ar.post_idx",   64'(o_beat_idx),   64'd0);
        $display("[TB] reset pulse mid-burst applied");
        send_req(9'h00A, 32'h200, 8'd0, 3'd2, 2'd1);
        beat("ar_new0", 32'h200, 4'hF, 8'd0, 1'b1, 1'b0);
        burst_done("ar_new");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
